// File: rtl/ctrl_pipe.sv
// Control-side pipeline for a five-stage core: carries decoded control through EX/MEM/WB,
// detects load-use hazards and produces the EX operand forwarding selects.
module ctrl_pipe #(
   parameter int CTRL_W = 8,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic [REG_AW-1:0] rs1_i,
   input  logic [REG_AW-1:0] rs2_i,
   input  logic              freeze_i,
   output logic              stall_o,
   output logic [1:0]        ex_aluop_o,
   output logic              ex_alusrc_o,
   output logic              mem_memread_o,
   output logic              mem_memwrite_o,
   output logic              wb_regwrite_o,
   output logic              wb_memtoreg_o,
   output logic [REG_AW-1:0] wb_rd_o,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o
);

   // ID/EX
   logic [1:0]        idex_aluop;
   logic              idex_alusrc;
   logic              idex_regwrite;
   logic              idex_memtoreg;
   logic              idex_memread;
   logic              idex_memwrite;
   logic [REG_AW-1:0] idex_rd;
   logic [REG_AW-1:0] idex_rs1;
   logic [REG_AW-1:0] idex_rs2;

   // EX/MEM
   logic              exmem_regwrite;
   logic              exmem_memtoreg;
   logic              exmem_memread;
   logic              exmem_memwrite;
   logic [REG_AW-1:0] exmem_rd;

   // MEM/WB
   logic              memwb_regwrite;
   logic              memwb_memtoreg;
   logic [REG_AW-1:0] memwb_rd;

   // Branch resolves in ID, so bit 0 never enters the pipe.
   logic unused_branch;
   assign unused_branch = ctrl_i[0];

   assign stall_o = idex_memread && (idex_rd != '0) &&
                    ((idex_rd == rs1_i) || (idex_rd == rs2_i));

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         idex_aluop     <= '0;
         idex_alusrc    <= 1'b0;
         idex_regwrite  <= 1'b0;
         idex_memtoreg  <= 1'b0;
         idex_memread   <= 1'b0;
         idex_memwrite  <= 1'b0;
         idex_rd        <= '0;
         idex_rs1       <= '0;
         idex_rs2       <= '0;
         exmem_regwrite <= 1'b0;
         exmem_memtoreg <= 1'b0;
         exmem_memread  <= 1'b0;
         exmem_memwrite <= 1'b0;
         exmem_rd       <= '0;
         memwb_regwrite <= 1'b0;
         memwb_memtoreg <= 1'b0;
         memwb_rd       <= '0;
      end else if (!freeze_i) begin
         if (stall_o) begin
            idex_aluop    <= '0;
            idex_alusrc   <= 1'b0;
            idex_regwrite <= 1'b0;
            idex_memtoreg <= 1'b0;
            idex_memread  <= 1'b0;
            idex_memwrite <= 1'b0;
            idex_rd       <= '0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
         end else begin
            idex_aluop    <= ctrl_i[7:6];
            idex_alusrc   <= ctrl_i[5];
            idex_regwrite <= ctrl_i[4];
            idex_memtoreg <= ctrl_i[3];
            idex_memread  <= ctrl_i[2];
            idex_memwrite <= ctrl_i[1];
            idex_rd       <= rd_i;
            idex_rs1      <= rs1_i;
            idex_rs2      <= rs2_i;
         end
         exmem_regwrite <= idex_regwrite;
         exmem_memtoreg <= idex_memtoreg;
         exmem_memread  <= idex_memread;
         exmem_memwrite <= idex_memwrite;
         exmem_rd       <= idex_rd;
         memwb_regwrite <= exmem_regwrite;
         memwb_memtoreg <= exmem_memtoreg;
         memwb_rd       <= exmem_rd;
      end
   end

   assign ex_aluop_o     = idex_aluop;
   assign ex_alusrc_o    = idex_alusrc;
   assign mem_memread_o  = exmem_memread;
   assign mem_memwrite_o = exmem_memwrite;
   assign wb_regwrite_o  = memwb_regwrite;
   assign wb_memtoreg_o  = memwb_memtoreg;
   assign wb_rd_o        = memwb_rd;

   // EX/MEM is checked first so the most recent producer wins.
   always_comb begin
      fwd_a_o = 2'b00;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_rs1))
         fwd_a_o = 2'b10;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_rs1))
         fwd_a_o = 2'b01;
   end

   always_comb begin
      fwd_b_o = 2'b00;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_rs2))
         fwd_b_o = 2'b10;
      else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_rs2))
         fwd_b_o = 2'b01;
   end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a stage-list model checked against the DUT every cycle,
// plus literal checks at the scenario points.
module tb_ctrl_pipe;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] ctrl_i;
   logic [4:0] rd_i, rs1_i, rs2_i;
   logic       freeze_i;
   logic       stall_o;
   logic [1:0] ex_aluop_o;
   logic       ex_alusrc_o;
   logic       mem_memread_o, mem_memwrite_o;
   logic       wb_regwrite_o, wb_memtoreg_o;
   logic [4:0] wb_rd_o;
   logic [1:0] fwd_a_o, fwd_b_o;

   always #5 clk_i = ~clk_i;

   ctrl_pipe #(.CTRL_W(8), .REG_AW(5)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .rd_i(rd_i), .rs1_i(rs1_i),
      .rs2_i(rs2_i), .freeze_i(freeze_i), .stall_o(stall_o), .ex_aluop_o(ex_aluop_o),
      .ex_alusrc_o(ex_alusrc_o), .mem_memread_o(mem_memread_o),
      .mem_memwrite_o(mem_memwrite_o), .wb_regwrite_o(wb_regwrite_o),
      .wb_memtoreg_o(wb_memtoreg_o), .wb_rd_o(wb_rd_o), .fwd_a_o(fwd_a_o),
      .fwd_b_o(fwd_b_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic en = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Whole instructions travel through EX, MEM, WB; outputs are read off by field.
   typedef struct packed {
      logic [7:0] ctrl;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } instr_t;

   instr_t m_ex = '0, m_mem = '0, m_wb = '0;

   function automatic logic exp_stall();
      return m_ex.ctrl[2] && (m_ex.rd != 0) && ((m_ex.rd == rs1_i) || (m_ex.rd == rs2_i));
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] src);
      if (m_mem.ctrl[4] && m_mem.rd != 0 && m_mem.rd == src) return 2'b10;
      if (m_wb.ctrl[4] && m_wb.rd != 0 && m_wb.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk_i) begin
      logic stl;
      if (!rst_i) begin
         m_ex = '0; m_mem = '0; m_wb = '0;
      end else if (!freeze_i) begin
         stl   = exp_stall();
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = stl ? instr_t'('0) : instr_t'({ctrl_i, rd_i, rs1_i, rs2_i});
      end
   end

   always @(negedge clk_i) begin
      if (en) begin
         chk("stall",    stall_o,        exp_stall());
         chk("ex_aluop", ex_aluop_o,     m_ex.ctrl[7:6]);
         chk("ex_alusrc", ex_alusrc_o,   m_ex.ctrl[5]);
         chk("mem_rd_en", mem_memread_o, m_mem.ctrl[2]);
         chk("mem_wr_en", mem_memwrite_o, m_mem.ctrl[1]);
         chk("wb_regwr", wb_regwrite_o,  m_wb.ctrl[4]);
         chk("wb_m2r",   wb_memtoreg_o,  m_wb.ctrl[3]);
         chk("wb_rd",    wb_rd_o,        m_wb.rd);
         chk("fwd_a",    fwd_a_o,        exp_fwd(m_ex.rs1));
         chk("fwd_b",    fwd_b_o,        exp_fwd(m_ex.rs2));
      end
   end

   task automatic drive(input logic [7:0] c, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic frz = 1'b0, input logic rst = 1'b1);
      @(posedge clk_i);
      #1;
      ctrl_i = c; rd_i = d; rs1_i = s1; rs2_i = s2; freeze_i = frz; rst_i = rst;
      #1;
   endtask

   initial begin
      rst_i = 1'b0; freeze_i = 1'b0; ctrl_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      en = 1'b1;
      #1;
      chk("lit_rst_stall", stall_o, 0);
      chk("lit_rst_wbregwr", wb_regwrite_o, 0);
      chk("lit_rst_fwd_a", fwd_a_o, 0);
      chk("lit_rst_fwd_b", fwd_b_o, 0);

      // flow
      drive(8'h90, 5, 1, 2);
      drive(8'h00, 0, 0, 0);
      chk("lit_flow_aluop", ex_aluop_o, 2'b10);
      drive(8'h00, 0, 0, 0);
      drive(8'h00, 0, 0, 0);
      chk("lit_flow_wbregwr", wb_regwrite_o, 1);
      chk("lit_flow_wbrd", wb_rd_o, 5);

      // load-use
      drive(8'h3C, 7, 0, 0);
      drive(8'h90, 8, 7, 0);
      chk("lit_lu_stall", stall_o, 1);
      drive(8'h90, 8, 7, 0);
      chk("lit_lu_stall_off", stall_o, 0);
      chk("lit_lu_bubble_aluop", ex_aluop_o, 0);
      chk("lit_lu_bubble_alusrc", ex_alusrc_o, 0);
      chk("lit_lu_ld_mem", mem_memread_o, 1);
      drive(8'h00, 0, 0, 0);
      chk("lit_lu_r_in_ex", ex_aluop_o, 2'b10);
      chk("lit_lu_fwd_a", fwd_a_o, 2'b01);

      // forward priority
      drive(8'h30, 3, 0, 0);
      drive(8'h30, 3, 0, 0);
      drive(8'h90, 9, 3, 3);
      drive(8'h00, 0, 0, 0);
      chk("lit_prio_fwd_a", fwd_a_o, 2'b10);
      chk("lit_prio_fwd_b", fwd_b_o, 2'b10);

      // WB forward, then x0
      drive(8'h30, 4, 0, 0);
      drive(8'h00, 0, 0, 0);
      drive(8'h90, 10, 0, 4);
      drive(8'h00, 0, 0, 0);
      chk("lit_wb_fwd_b", fwd_b_o, 2'b01);
      chk("lit_wb_fwd_a", fwd_a_o, 2'b00);
      drive(8'h30, 0, 0, 0);
      drive(8'h00, 0, 0, 0);
      drive(8'h90, 10, 0, 0);
      drive(8'h00, 0, 0, 0);
      chk("lit_x0_fwd_b", fwd_b_o, 2'b00);
      drive(8'h3C, 0, 0, 0);
      drive(8'h90, 10, 0, 0);
      chk("lit_x0_stall", stall_o, 0);

      // store never forwards
      drive(8'h22, 6, 0, 0);
      drive(8'h90, 10, 6, 6);
      drive(8'h00, 0, 0, 0);
      chk("lit_st_fwd_a", fwd_a_o, 2'b00);
      chk("lit_st_fwd_b", fwd_b_o, 2'b00);

      // freeze with A in WB, ld B in MEM, store C in EX
      drive(8'h90, 11, 0, 0);
      drive(8'h3C, 12, 1, 1);
      drive(8'h22, 0, 2, 13);
      drive(8'h90, 14, 0, 0, 1'b1);
      drive(8'h90, 14, 0, 0, 1'b1);
      drive(8'h90, 14, 0, 0, 1'b1);
      drive(8'h90, 14, 0, 0, 1'b0);
      chk("lit_frz_wbrd", wb_rd_o, 11);
      chk("lit_frz_wbregwr", wb_regwrite_o, 1);
      chk("lit_frz_memrd", mem_memread_o, 1);
      chk("lit_frz_exsrc", ex_alusrc_o, 1);
      drive(8'h00, 0, 0, 0);
      chk("lit_res_wbrd", wb_rd_o, 12);
      chk("lit_res_wbm2r", wb_memtoreg_o, 1);
      chk("lit_res_memwr", mem_memwrite_o, 1);
      chk("lit_res_aluop", ex_aluop_o, 2'b10);

      // reset with ld in EX, addi in MEM
      drive(8'h30, 16, 0, 0);
      drive(8'h3C, 15, 0, 0);
      drive(8'h00, 0, 0, 0, 1'b0, 1'b0);
      chk("lit_prerst_exsrc", ex_alusrc_o, 1);
      drive(8'h00, 0, 0, 0);
      chk("lit_mrst_exsrc", ex_alusrc_o, 0);
      chk("lit_mrst_memrd", mem_memread_o, 0);
      chk("lit_mrst_wbregwr", wb_regwrite_o, 0);
      chk("lit_mrst_wbrd", wb_rd_o, 0);
      for (int i = 0; i < 3; i++) begin
         drive(8'h00, 0, 0, 0);
         chk("lit_mrst_drain", wb_regwrite_o, 0);
      end

      drive(8'h00, 0, 0, 0);
      @(negedge clk_i);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
